// File: rtl/ppu_mode_sequencer.sv
// rtl/ppu_mode_sequencer.sv - per-dot PPU mode/line sequencer with V-blank and STAT interrupts
//
// Purpose: owns the dot counter, LY and PPU_MODE for the pixel pipeline. Starts
// OAM scan and draw phases, ends draw on draw_done or timeout, and raises the
// V-blank and STAT (LCDC) interrupt request pulses.
//
// Ports:
//   clk          system clock, one dot per cycle
//   rst          asynchronous active-high reset
//   lcd_en       LCDC bit 7; low holds the sequencer idle at reset values
//   draw_done    one-cycle pulse from the pixel pipeline (160th pixel pushed)
//   lyc          LYC compare value
//   stat_en      STAT source enables: [3] LYC, [2] mode 2, [1] mode 1, [0] mode 0
//   PPU_MODE     0 H-blank, 1 V-blank, 2 OAM scan, 3 draw
//   LY           current line 0..153
//   dot          dot within the line 0..455
//   scan_start   pulse in the cycle mode 2 begins
//   draw_start   pulse in the cycle mode 3 begins
//   lyc_match    combinational LY == lyc
//   IRQ_V_BLANK  one-cycle V-blank request
//   IRQ_LCDC     one-cycle STAT request on a rising edge of the STAT line

module ppu_mode_sequencer #(
    parameter int DOTS_PER_LINE = 456,
    parameter int SCAN_DOTS     = 80,
    parameter int MAX_DRAW_DOTS = 289,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       draw_done,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_en,
    output logic [1:0] PPU_MODE,
    output logic [7:0] LY,
    output logic [8:0] dot,
    output logic       scan_start,
    output logic       draw_start,
    output logic       lyc_match,
    output logic       IRQ_V_BLANK,
    output logic       IRQ_LCDC
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_DRAW   = 2'd3
    } mode_t;

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SCAN_LAST = 9'(SCAN_DOTS - 1);
    // Last dot that may still be in mode 3; the following edge forces H-blank.
    localparam logic [8:0] DRAW_LAST = 9'(SCAN_DOTS + MAX_DRAW_DOTS - 1);
    localparam logic [7:0] LAST_LINE = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);

    mode_t      mode_q, mode_d;
    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    logic       running_q, running_d;
    logic       stat_q, stat_d;
    logic       scan_q, scan_d;
    logic       draw_q, draw_d;
    logic       vbl_q, vbl_d;
    logic       lcdc_q, lcdc_d;

    always_comb begin
        dot_d     = dot_q;
        ly_d      = ly_q;
        mode_d    = mode_q;
        running_d = running_q;
        scan_d    = 1'b0;
        draw_d    = 1'b0;
        vbl_d     = 1'b0;
        stat_d    = 1'b0;
        lcdc_d    = 1'b0;

        if (!lcd_en) begin
            dot_d     = '0;
            ly_d      = '0;
            mode_d    = MODE_HBLANK;
            running_d = 1'b0;
        end else if (!running_q) begin
            // First enabled edge after idle: line 0 starts directly in OAM scan.
            dot_d     = '0;
            ly_d      = '0;
            mode_d    = MODE_SCAN;
            running_d = 1'b1;
            scan_d    = 1'b1;
        end else if (dot_q == LAST_DOT) begin
            dot_d = '0;
            ly_d  = (ly_q == LAST_LINE) ? 8'd0 : ly_q + 8'd1;
            if (ly_d < VIS_LINES) begin
                mode_d = MODE_SCAN;
                scan_d = 1'b1;
            end else begin
                mode_d = MODE_VBLANK;
                vbl_d  = (ly_d == VIS_LINES);
            end
        end else begin
            dot_d = dot_q + 9'd1;
            case (mode_q)
                MODE_SCAN: begin
                    if (dot_q == SCAN_LAST) begin
                        mode_d = MODE_DRAW;
                        draw_d = 1'b1;
                    end
                end
                MODE_DRAW: begin
                    // draw_done and timeout on the same edge collapse into one exit.
                    if (draw_done || dot_q == DRAW_LAST) begin
                        mode_d = MODE_HBLANK;
                    end
                end
                default: begin
                end
            endcase
        end

        if (lcd_en) begin
            // STAT line is evaluated on the state being entered, so the
            // interrupt lines up with the first cycle of the new mode/line.
            stat_d = ((ly_d == lyc) & stat_en[3])
                   | ((mode_d == MODE_SCAN)   & stat_en[2])
                   | ((mode_d == MODE_VBLANK) & stat_en[1])
                   | ((mode_d == MODE_HBLANK) & stat_en[0]);
            lcdc_d = stat_d & ~stat_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_HBLANK;
            dot_q     <= '0;
            ly_q      <= '0;
            running_q <= 1'b0;
            stat_q    <= 1'b0;
            scan_q    <= 1'b0;
            draw_q    <= 1'b0;
            vbl_q     <= 1'b0;
            lcdc_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            dot_q     <= dot_d;
            ly_q      <= ly_d;
            running_q <= running_d;
            stat_q    <= stat_d;
            scan_q    <= scan_d;
            draw_q    <= draw_d;
            vbl_q     <= vbl_d;
            lcdc_q    <= lcdc_d;
        end
    end

    assign PPU_MODE    = mode_q;
    assign LY          = ly_q;
    assign dot         = dot_q;
    assign scan_start  = scan_q;
    assign draw_start  = draw_q;
    assign IRQ_V_BLANK = vbl_q;
    assign IRQ_LCDC    = lcdc_q;
    assign lyc_match   = (ly_q == lyc);

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// tb/tb_ppu_mode_sequencer.sv - scoreboard bench for ppu_mode_sequencer against a frame-time reference model

module tb_ppu_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_en;
    logic       draw_done;
    logic [7:0] lyc;
    logic [3:0] stat_en;
    logic [1:0] PPU_MODE;
    logic [7:0] LY;
    logic [8:0] dot;
    logic       scan_start;
    logic       draw_start;
    logic       lyc_match;
    logic       IRQ_V_BLANK;
    logic       IRQ_LCDC;

    ppu_mode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_en     (lcd_en),
        .draw_done  (draw_done),
        .lyc        (lyc),
        .stat_en    (stat_en),
        .PPU_MODE   (PPU_MODE),
        .LY         (LY),
        .dot        (dot),
        .scan_start (scan_start),
        .draw_start (draw_start),
        .lyc_match  (lyc_match),
        .IRQ_V_BLANK(IRQ_V_BLANK),
        .IRQ_LCDC   (IRQ_LCDC)
    );

    always #5 clk = ~clk;

    localparam int LINE  = 456;
    localparam int FRAME = LINE * 154;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] ly;
        logic [8:0] dot;
        logic       scan;
        logic       draw;
        logic       irqv;
        logic       irql;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errs   = 0;

    // Reference model state: position within the frame as a single cycle index.
    bit   m_run  = 0;
    bit   m_stat = 0;
    int   m_t    = 0;
    int   m_end  = 369;
    int   m_ly   = 0;
    int   m_dot  = 0;

    int   win    = 0;
    int   lcdc1  = 0;
    int   match1 = 0;
    int   lcdc2  = 0;
    int   vbl_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] mode_at(input int t, input int e_end);
        int l = t / LINE;
        int d = t % LINE;
        if (l >= 144) return 2'd1;
        if (d < 80) return 2'd2;
        if (d < e_end) return 2'd3;
        return 2'd0;
    endfunction

    always @(posedge clk) begin : model
        exp_t       e;
        logic [1:0] md;
        bit         st;
        e = '0;
        if (rst || !lcd_en) begin
            m_run  = 0;
            m_stat = 0;
            m_t    = 0;
        end else begin
            if (!m_run) begin
                m_run = 1;
                m_t   = 0;
                m_end = 369;
            end else begin
                if (mode_at(m_t, m_end) == 2'd3 && draw_done) m_end = (m_t % LINE) + 1;
                m_t = (m_t + 1) % FRAME;
                if (m_t % LINE == 0) m_end = 369;
            end
            md     = mode_at(m_t, m_end);
            e.mode = md;
            e.ly   = 8'(m_t / LINE);
            e.dot  = 9'(m_t % LINE);
            e.scan = (md == 2'd2) && (m_t % LINE == 0);
            e.draw = (m_t / LINE < 144) && (m_t % LINE == 80);
            e.irqv = (m_t == 144 * LINE);
            st = (e.ly == lyc && stat_en[3]) || (md == 2'd2 && stat_en[2])
              || (md == 2'd1 && stat_en[1]) || (md == 2'd0 && stat_en[0]);
            e.irql = st && !m_stat;
            m_stat = st;
        end
        m_ly  = m_t / LINE;
        m_dot = m_t % LINE;
        q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = q.pop_front();
            chk("outputs", {PPU_MODE, LY, dot, scan_start, draw_start, IRQ_V_BLANK, IRQ_LCDC, lyc_match},
                {e, (e.ly == lyc)});
        end
        if (win == 1) begin
            lcdc1  += int'(IRQ_LCDC);
            match1 += int'(lyc_match);
        end
        if (win == 2) lcdc2 += int'(IRQ_LCDC);
        vbl_cnt += int'(IRQ_V_BLANK);
    end

    task automatic run_until(input int ly, input int dt, input bit rnd_dd, input bit rnd_stat);
        for (int n = 0; n < 80000; n++) begin
            @(negedge clk);
            if (m_ly == ly && m_dot == dt) begin
                draw_done = 1'b0;
                return;
            end
            draw_done = rnd_dd ? ($urandom_range(0, 149) == 0) : 1'b0;
            if (rnd_stat && $urandom_range(0, 99) == 0) begin
                lyc     = 8'($urandom_range(0, 160));
                stat_en = 4'($urandom);
            end
        end
        chk("wait_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b1; lcd_en = 1'b0; draw_done = 1'b0; lyc = 8'd10; stat_en = 4'b1000;
        @(posedge clk);
        #1;
        chk("reset_state", {PPU_MODE, LY, dot, scan_start, draw_start, IRQ_V_BLANK, IRQ_LCDC}, 0);
        @(negedge clk);
        rst = 1'b0; lcd_en = 1'b1;
        repeat (100) @(negedge clk);

        // Asynchronous reset mid-line: outputs clear without a clock edge.
        rst = 1'b1;
        #1;
        chk("async_reset", {PPU_MODE, LY, dot, scan_start, draw_start, IRQ_V_BLANK, IRQ_LCDC}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_mode", PPU_MODE, 2);
        chk("restart_scan_start", scan_start, 1);

        // Line 0: draw ends on draw_done at dot 252.
        run_until(0, 252, 0, 0);
        draw_done = 1'b1;
        // Line 1: no draw_done (timeout), stray draw_done in H-blank.
        run_until(1, 400, 0, 0);
        draw_done = 1'b1;

        // LYC interrupt window.
        run_until(2, 0, 1, 0);
        win = 1;
        run_until(100, 0, 1, 0);
        win = 0;
        chk("lyc_irq_count", lcdc1, 1);
        chk("lyc_match_cycles", match1, LINE);

        // Random STAT traffic, then STAT blocking across the V-blank entry.
        run_until(131, 0, 1, 1);
        lyc = 8'd200; stat_en = 4'b0011;
        run_until(143, 0, 1, 0);
        win = 2;
        run_until(144, 1, 0, 0);
        win = 0;
        chk("stat_block_irq_count", lcdc2, 1);
        chk("vblank_count_first", vbl_cnt, 1);

        run_until(0, 50, 1, 1);
        chk("vblank_count_frame", vbl_cnt, 1);

        // Disable mid-line: next edge applies reset values, draw_done ignored.
        lcd_en = 1'b0;
        draw_done = 1'b1;
        @(posedge clk);
        #1;
        chk("disable_state", {PPU_MODE, LY, dot, scan_start, draw_start, IRQ_V_BLANK, IRQ_LCDC}, 0);
        repeat (4) @(negedge clk);
        draw_done = 1'b0;
        lcd_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            draw_done = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 49) == 0) begin
                lyc     = 8'($urandom_range(0, 3));
                stat_en = 4'($urandom);
            end
        end
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule

// File: doc/ppu_mode_sequencer.md
Name: ppu_mode_sequencer

Overview:
- Per-dot timing controller for the PPU pixel pipeline.
- Owns the dot counter, LY and PPU_MODE, and starts the OAM-scan and draw phases in the fetcher/FIFO datapath.
- Ends the draw phase on the datapath's done pulse, or on a timeout.
- Generates the V-blank and STAT (LCDC) interrupt requests for the CPU interrupt controller.

Parameters:
- DOTS_PER_LINE, 456, dots per scanline.
- SCAN_DOTS, 80, length of mode 2 (OAM scan).
- MAX_DRAW_DOTS, 289, longest allowed mode 3 before forced exit.
- VISIBLE_LINES, 144, lines 0..143 are drawn.
- TOTAL_LINES, 154, lines per frame.

Ports:
- clk  in  1  system clock, one dot per cycle.
- rst  in  1  asynchronous, active-high reset.
- lcd_en  in  1  LCDC bit 7; low holds the sequencer idle.
- draw_done  in  1  one-cycle pulse from the pixel pipeline: 160th pixel pushed.
- lyc  in  8  LYC register value.
- stat_en  in  4  STAT enables: [3] LYC, [2] mode 2, [1] mode 1, [0] mode 0.
- PPU_MODE  out  2  0 H-blank, 1 V-blank, 2 OAM scan, 3 draw.
- LY  out  8  current line.
- dot  out  9  dot within the line, 0..455.
- scan_start  out  1  pulse when mode 2 begins.
- draw_start  out  1  pulse when mode 3 begins.
- lyc_match  out  1  LY == lyc (combinational).
- IRQ_V_BLANK  out  1  one-cycle pulse.
- IRQ_LCDC  out  1  one-cycle pulse.

Behaviour:
- Reset values: dot=0, LY=0, PPU_MODE=0, all pulse outputs 0, internal stat_line=0.
- Registered outputs: all outputs except lyc_match are registered.
- Idle (lcd_en=0):
  - Registers forced to reset values on every edge; draw_done ignored; no interrupts.
  - If lcd_en drops mid-operation, the next edge applies reset values.
- Restart: the first edge with lcd_en=1 after idle sets dot=0, LY=0, PPU_MODE=2 and pulses scan_start.
- Counters:
  - dot increments each cycle; 455 wraps to 0 and LY increments.
  - LY at 153 with dot 455 wraps to 0.
- Visible lines (LY<144):
  - dot 0..79: mode 2.
  - Edge where dot goes 79->80: mode becomes 3, draw_start pulses.
  - Mode 3 -> mode 0 on the edge after draw_done is sampled high.
  - Forced timeout: mode 3 -> mode 0 on the edge where dot would become SCAN_DOTS+MAX_DRAW_DOTS (369), if draw_done never arrived.
  - Mode 0 holds to dot 455. The wrap edge enters mode 2 (scan_start pulses) when the new LY<144.
- draw_done outside mode 3 is ignored. A draw_done on the same cycle as the timeout produces a single transition.
- V-blank: the wrap edge into LY=144 sets mode 1 and pulses IRQ_V_BLANK for one cycle, once per frame. Mode 1 holds for lines 144..153.
- Frame length: exactly 70224 cycles.
- STAT line:
  - stat_line_next = (lyc_match&en[3]) | (mode==2&en[2]) | (mode==1&en[1]) | (mode==0&en[0]), evaluated on next-state mode/LY.
  - IRQ_LCDC pulses only on a 0->1 transition of the registered stat_line. If the line stays high across a mode change, no new pulse (STAT blocking).
- lyc_match: combinational compare of the registered LY with lyc.
- Width rules: dot is 9-bit and LY is 8-bit; no value outside 0..455 / 0..153 is ever output.

Test Plan:
- Reset values: assert rst mid-line, with lcd_en=1 -> all outputs 0 immediately (asynchronous). Deassert -> first edge gives PPU_MODE=2 with scan_start=1.
- Normal line: draw_done pulsed at dot 252 on LY=0 -> mode 2 for dots 0..79, draw_start at dot 80, mode 3 for dots 80..252, mode 0 for dots 253..455, LY=1 at the next dot 0.
- Draw timeout: no draw_done -> mode 3 through dot 368, mode 0 at dot 369. A stray draw_done in mode 0 has no effect.
- Frame timing: run free -> IRQ_V_BLANK pulses exactly once every 70224 cycles at LY=144 dot 0. Mode stays 1 through LY=153, then LY=0 mode 2.
- LYC interrupt: lyc=10, stat_en=4'b1000 -> IRQ_LCDC pulses once at LY=10 dot 0, and lyc_match is high only during LY=10.
- STAT blocking and disable:
  - stat_en=4'b0011 -> exactly one IRQ_LCDC entering mode 0 of line 143; no pulse entering mode 1.
  - lcd_en low mid-frame -> LY=0, dot=0, PPU_MODE=0 next edge, no pulses.
